// File: rtl/pe_feed_pkg.sv
// rtl/pe_feed_pkg.sv - shared state type and counter sizing for the PE array feeder
package pe_feed_pkg;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ROWS       = 9;
    localparam int DEF_COLS       = 8;
    localparam int DEF_MAC_LAT    = 10;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ROW_CNT_W   = cnt_w(DEF_ROWS);
    localparam int COL_CNT_W   = cnt_w(DEF_COLS);
    localparam int DRAIN_MAX   = DEF_ROWS - 1 + DEF_COLS + DEF_MAC_LAT;
    localparam int DRAIN_CNT_W = cnt_w(DRAIN_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_W_COMMIT,
        S_STREAM,
        S_F_LAUNCH,
        S_DRAIN,
        S_DONE
    } feed_state_t;
endpackage

// File: rtl/pe_array_feeder_if.sv
// rtl/pe_array_feeder_if.sv - weight and fmap valid/ready streams into the feeder
interface pe_array_feeder_if #(
    parameter int DATA_WIDTH = pe_feed_pkg::DEF_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_valid;
    logic                  w_ready;
    logic [DATA_WIDTH-1:0] f_data;
    logic                  f_valid;
    logic                  f_ready;

    modport master (output w_data, w_valid, f_data, f_valid, input w_ready, f_ready);
    modport slave  (input w_data, w_valid, f_data, f_valid, output w_ready, f_ready);
endinterface

// File: rtl/pe_skew_line.sv
// rtl/pe_skew_line.sv - DEPTH-stage shift of {en,data}; DEPTH=0 passes straight through
module pe_skew_line #(
    parameter int DEPTH      = 0,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rest_n,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_en,
    output logic [DATA_WIDTH-1:0] o_data
);
    if (DEPTH == 0) begin : g_wire
        logic w_unused_clk;
        assign w_unused_clk = i_clk ^ i_rest_n;
        assign o_en   = i_en;
        assign o_data = i_data;
    end else begin : g_shift
        logic [DATA_WIDTH:0] r_sr [DEPTH];

        always_ff @(posedge i_clk or negedge i_rest_n) begin
            if (!i_rest_n) begin
                for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
            end else begin
                r_sr[0] <= {i_en, i_data};
                for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
            end
        end

        assign {o_en, o_data} = r_sr[DEPTH-1];
    end
endmodule

// File: rtl/pe_array_feeder.sv
// rtl/pe_array_feeder.sv - weight loader and skewed fmap launcher for the MPE array; PE_ARRAY_FEEDER_PERF_EN adds o_stall_cnt
module pe_array_feeder
    import pe_feed_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ROWS       = DEF_ROWS,
    parameter int COLS       = DEF_COLS,
    parameter int MAC_LAT    = DEF_MAC_LAT
) (
    input  logic                       i_clk,
    input  logic                       i_rest_n,
    input  logic                       i_start,
    input  logic [15:0]                i_num_vec,
    pe_array_feeder_if.slave           s_if,
    output logic [COLS*DATA_WIDTH-1:0] o_weight_top,
    output logic [ROWS-1:0]            o_weight_en,
    output logic [ROWS*DATA_WIDTH-1:0] o_fmap_left,
    output logic [ROWS-1:0]            o_left_en,
    output logic [ROWS-1:0]            o_right_en,
    output logic                       o_busy,
    output logic                       o_done
`ifdef PE_ARRAY_FEEDER_PERF_EN
    ,
    output logic [31:0]                o_stall_cnt
`endif
);
    localparam int RW   = cnt_w(ROWS);
    localparam int CW   = cnt_w(COLS);
    localparam int DMAX = ROWS - 1 + COLS + MAC_LAT;
    localparam int DRW  = cnt_w(DMAX + 1);

    feed_state_t               r_state, w_next;
    logic [CW-1:0]             r_col_cnt;
    logic [RW-1:0]             r_row_cnt, r_fk_cnt;
    logic [15:0]               r_num_vec, r_vec_cnt;
    logic [DRW-1:0]            r_drain;
    logic [DATA_WIDTH-1:0]     r_w_stage [COLS];
    logic [DATA_WIDTH-1:0]     r_f_stage [ROWS];
    logic [COLS*DATA_WIDTH-1:0] r_weight_hold, w_weight_row;
    logic                      w_launch, w_w_ready, w_f_ready;

    always_comb begin
        w_next    = r_state;
        w_w_ready = 1'b0;
        w_f_ready = 1'b0;
        w_launch  = 1'b0;
        case (r_state)
            S_IDLE:     if (i_start) w_next = S_LOAD_W;
            S_LOAD_W: begin
                w_w_ready = 1'b1;
                if (s_if.w_valid && r_col_cnt == CW'(COLS-1)) w_next = S_W_COMMIT;
            end
            S_W_COMMIT: begin
                if (r_row_cnt == RW'(ROWS-1))
                    w_next = (r_num_vec == 16'd0) ? S_DRAIN : S_STREAM;
                else
                    w_next = S_LOAD_W;
            end
            S_STREAM: begin
                w_f_ready = 1'b1;
                if (s_if.f_valid && r_fk_cnt == RW'(ROWS-1)) w_next = S_F_LAUNCH;
            end
            S_F_LAUNCH: begin
                w_launch = 1'b1;
                w_next   = (r_vec_cnt + 16'd1 == r_num_vec) ? S_DRAIN : S_STREAM;
            end
            // counter reaches zero on the same edge that enters DONE
            S_DRAIN:    if (r_drain == DRW'(1)) w_next = S_DONE;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rest_n) begin
        if (!i_rest_n) begin
            r_state       <= S_IDLE;
            r_col_cnt     <= '0;
            r_row_cnt     <= '0;
            r_fk_cnt      <= '0;
            r_num_vec     <= '0;
            r_vec_cnt     <= '0;
            r_drain       <= '0;
            r_weight_hold <= '0;
            for (int c = 0; c < COLS; c++) r_w_stage[c] <= '0;
            for (int r = 0; r < ROWS; r++) r_f_stage[r] <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_num_vec <= i_num_vec;
                    r_vec_cnt <= '0;
                    r_row_cnt <= '0;
                    r_col_cnt <= '0;
                    r_fk_cnt  <= '0;
                end
                S_LOAD_W: if (s_if.w_valid) begin
                    r_w_stage[r_col_cnt] <= s_if.w_data;
                    r_col_cnt <= (r_col_cnt == CW'(COLS-1)) ? '0 : r_col_cnt + CW'(1);
                end
                S_W_COMMIT: begin
                    r_weight_hold <= w_weight_row;
                    r_row_cnt     <= r_row_cnt + RW'(1);
                end
                S_STREAM: if (s_if.f_valid) begin
                    r_f_stage[r_fk_cnt] <= s_if.f_data;
                    r_fk_cnt <= (r_fk_cnt == RW'(ROWS-1)) ? '0 : r_fk_cnt + RW'(1);
                end
                S_F_LAUNCH: r_vec_cnt <= r_vec_cnt + 16'd1;
                S_DRAIN:    r_drain   <= r_drain - DRW'(1);
                default: ;
            endcase
            if (w_next == S_DRAIN && r_state != S_DRAIN) r_drain <= DRW'(DMAX);
        end
    end

    always_comb begin
        w_weight_row = '0;
        for (int c = 0; c < COLS; c++) w_weight_row[c*DATA_WIDTH +: DATA_WIDTH] = r_w_stage[c];
    end

    assign o_weight_top = (r_state == S_W_COMMIT) ? w_weight_row : r_weight_hold;
    assign o_weight_en  = (r_state == S_W_COMMIT) ? (ROWS'(1) << r_row_cnt) : '0;
    assign s_if.w_ready = w_w_ready;
    assign s_if.f_ready = w_f_ready;
    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = (r_state == S_DONE);

    wire [ROWS-1:0]            w_left_en;
    wire [ROWS*DATA_WIDTH-1:0] w_fmap_left;

    // row r sees the launched vector r+1 cycles after F_LAUNCH: r skew stages plus the output register
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic                  w_sk_en;
        logic [DATA_WIDTH-1:0] w_sk_data;
        logic                  r_en;
        logic [DATA_WIDTH-1:0] r_data;

        pe_skew_line #(.DEPTH(r), .DATA_WIDTH(DATA_WIDTH)) u_skew (
            .i_clk    (i_clk),
            .i_rest_n (i_rest_n),
            .i_en     (w_launch),
            .i_data   (r_f_stage[r]),
            .o_en     (w_sk_en),
            .o_data   (w_sk_data)
        );

        always_ff @(posedge i_clk or negedge i_rest_n) begin
            if (!i_rest_n) begin
                r_en   <= 1'b0;
                r_data <= '0;
            end else begin
                r_en <= w_sk_en;
                if (w_sk_en) r_data <= w_sk_data;
            end
        end

        assign w_left_en[r] = r_en;
        assign w_fmap_left[r*DATA_WIDTH +: DATA_WIDTH] = r_data;
    end

    assign o_left_en   = w_left_en;
    assign o_right_en  = w_left_en;
    assign o_fmap_left = w_fmap_left;

`ifdef PE_ARRAY_FEEDER_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge i_clk or negedge i_rest_n) begin
        if (!i_rest_n) begin
            r_stall_cnt <= '0;
        end else if (r_state == S_IDLE && i_start) begin
            r_stall_cnt <= '0;
        end else if (r_state == S_STREAM && !s_if.f_valid && r_stall_cnt != '1) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_pe_array_feeder.sv
// tb/tb_pe_array_feeder.sv - randomized self-checking bench for pe_array_feeder
`timescale 1ns/1ps
module tb_pe_array_feeder;
    import pe_feed_pkg::*;

    localparam int DW      = 32;
    localparam int ROWS    = 9;
    localparam int COLS    = 8;
    localparam int MAC_LAT = 10;
    localparam int DRAIN   = ROWS - 1 + COLS + MAC_LAT;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic [15:0]          num_vec = '0;
    logic [COLS*DW-1:0]   weight_top;
    logic [ROWS-1:0]      weight_en, left_en, right_en;
    logic [ROWS*DW-1:0]   fmap_left;
    logic                 busy, done;
`ifdef PE_ARRAY_FEEDER_PERF_EN
    logic [31:0]          stall_cnt;
`endif

    pe_array_feeder_if #(.DATA_WIDTH(DW)) bus ();

    pe_array_feeder #(.DATA_WIDTH(DW), .ROWS(ROWS), .COLS(COLS), .MAC_LAT(MAC_LAT)) dut (
        .i_clk        (clk),
        .i_rest_n     (rst_n),
        .i_start      (start),
        .i_num_vec    (num_vec),
        .s_if         (bus.slave),
        .o_weight_top (weight_top),
        .o_weight_en  (weight_en),
        .o_fmap_left  (fmap_left),
        .o_left_en    (left_en),
        .o_right_en   (right_en),
        .o_busy       (busy),
        .o_done       (done)
`ifdef PE_ARRAY_FEEDER_PERF_EN
        ,
        .o_stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_weight_top"}, 64'(|weight_top), 0);
        check({tag, "_weight_en"},  64'(weight_en), 0);
        check({tag, "_fmap_left"},  64'(|fmap_left), 0);
        check({tag, "_left_en"},    64'(left_en), 0);
        check({tag, "_right_en"},   64'(right_en), 0);
        check({tag, "_busy"},       64'(busy), 0);
        check({tag, "_done"},       64'(done), 0);
        check({tag, "_w_ready"},    64'(bus.w_ready), 0);
        check({tag, "_f_ready"},    64'(bus.f_ready), 0);
    endtask

    logic [DW-1:0] w_words[$];
    logic [DW-1:0] f_words[$];

    // mode: 0 always valid, 1 fmap valid toggles 1-0-1, 2 random valid on both streams
    task automatic run_tile(input int nv, input int mode, input bit seq_data, input int rst_at, input int restart_at);
        int  w_idx = 0, f_idx = 0, exp_row = 0, exp_done = -1, stalls = 0, budget, pulses = 0;
        int  l_time[$];
        int  seen[ROWS];
        bit  finished = 0, restarted = 0, aborted = 0, vbit;

        w_words.delete();
        f_words.delete();
        for (int i = 0; i < ROWS*COLS; i++) w_words.push_back(seq_data ? 32'h3F80_0000 + i : $urandom());
        for (int i = 0; i < nv*ROWS; i++)   f_words.push_back(seq_data ? 32'h4000_0000 + (i % ROWS) : $urandom());
        foreach (seen[r]) seen[r] = 0;

        @(posedge clk); #1;
        start = 1'b1; num_vec = 16'(nv);
        @(posedge clk); #1;
        start = 1'b0; num_vec = 16'($urandom());
        budget = 400 + nv*ROWS*6;

        for (int k = 0; k < budget && !finished && !aborted; k++) begin
            vbit = (mode == 2) ? ($urandom_range(0, 9) < 6) : 1'b1;
            bus.w_valid = (w_idx < ROWS*COLS) && vbit;
            bus.w_data  = (w_idx < ROWS*COLS) ? w_words[w_idx] : '0;
            vbit = (mode == 1) ? (k % 2 == 0) : (mode == 2) ? ($urandom_range(0, 9) < 6) : 1'b1;
            bus.f_valid = (f_idx < nv*ROWS) && vbit;
            bus.f_data  = (f_idx < nv*ROWS) ? f_words[f_idx] : '0;
            if (restart_at > 0 && !restarted && f_idx >= restart_at) begin
                start = 1'b1; num_vec = 16'd2; restarted = 1;
            end else begin
                start = 1'b0;
            end

            @(negedge clk);
            if (weight_en != '0) begin
                if (exp_row >= ROWS) begin
                    check("w_extra_commit", 64'(weight_en), 0);
                end else begin
                    check($sformatf("w_en_row%0d", exp_row), 64'(weight_en), 64'(1) << exp_row);
                    check("w_ready_in_commit", 64'(bus.w_ready), 0);
                    check("w_words_before_commit", 64'(w_idx), 64'((exp_row + 1) * COLS));
                    for (int c = 0; c < COLS; c++)
                        check($sformatf("w_top_r%0d_c%0d", exp_row, c),
                              64'(weight_top[c*DW +: DW]), 64'(w_words[exp_row*COLS + c]));
                    if (exp_row == ROWS-1 && nv == 0) exp_done = cyc + DRAIN + 1;
                end
                exp_row++;
            end
            if (bus.w_valid && bus.w_ready) w_idx++;
            if (bus.f_ready && !bus.f_valid) stalls++;
            if (bus.f_valid && bus.f_ready) begin
                f_idx++;
                if (f_idx % ROWS == 0) begin
                    l_time.push_back(cyc + 2);
                    if (mode == 0 && l_time.size() > 1)
                        check("vec_throughput", 64'(l_time[$] - l_time[$-1]), 64'(ROWS + 1));
                    if (f_idx == nv*ROWS) exp_done = cyc + 2 + DRAIN;
                end
            end
            if (left_en != '0 || right_en != '0) check("right_eq_left", 64'(right_en), 64'(left_en));
            for (int r = 0; r < ROWS; r++) begin
                if (left_en[r]) begin
                    if (seen[r] >= l_time.size()) begin
                        check($sformatf("left_unexpected_r%0d", r), 64'(left_en[r]), 0);
                    end else begin
                        check($sformatf("left_time_r%0d_v%0d", r, seen[r]), 64'(cyc), 64'(l_time[seen[r]] + r));
                        check($sformatf("left_data_r%0d_v%0d", r, seen[r]),
                              64'(fmap_left[r*DW +: DW]), 64'(f_words[seen[r]*ROWS + r]));
                    end
                    seen[r]++;
                    pulses++;
                end
            end
            if (done) begin
                check("done_cycle", 64'(cyc), 64'(exp_done));
                finished = 1;
            end
            if (rst_at > 0 && f_idx >= rst_at) begin
                #2 rst_n = 1'b0;
                #1 check_all_zero("rst_async");
                bus.w_valid = 1'b0; bus.f_valid = 1'b0; start = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("rst_hold_done", 64'(done), 0);
                    check("rst_hold_busy", 64'(busy), 0);
                end
                rst_n = 1'b1;
                repeat (2) begin
                    @(negedge clk);
                    check("post_rst_done", 64'(done), 0);
                    check("post_rst_left_en", 64'(left_en), 0);
                end
                aborted = 1;
            end
            if (!aborted) begin
                @(posedge clk); #1;
            end
        end

        bus.w_valid = 1'b0;
        bus.f_valid = 1'b0;
        start = 1'b0;
        if (!aborted) begin
            check("done_seen", 64'(finished), 1);
            @(negedge clk);
            check("done_one_cycle", 64'(done), 0);
            check("idle_after_done", 64'(busy), 0);
            check("w_commit_count", 64'(exp_row), 64'(ROWS));
            check("left_pulse_count", 64'(pulses), 64'(nv*ROWS));
`ifdef PE_ARRAY_FEEDER_PERF_EN
            check("stall_cnt", 64'(stall_cnt), 64'(stalls));
`endif
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.w_valid = 1'b0;
        bus.f_valid = 1'b0;
        bus.w_data  = '0;
        bus.f_data  = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        run_tile(1, 0, 1, 0, 0);
        run_tile(3, 1, 0, 0, 0);
        run_tile(0, 0, 0, 0, 0);
        run_tile(4, 2, 0, ROWS + 4, 0);
        run_tile(2, 2, 0, 0, 0);
        run_tile(5, 0, 0, 0, 3);
        for (int t = 0; t < 3; t++) run_tile($urandom_range(1, 4), 2, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pe_array_feeder.md
Name: pe_array_feeder

Overview:
- Upstream control/data stage for the 9x8 MPE array.
- Consumes valid/ready streams of weight words and fmap words.
- Loads weights row by row into the PE weight registers through the per-row weight enables, then streams fmap vectors into the left edge of the array with a one-cycle-per-row skew, driving the left/right enables of each row.
- Tracks array drain latency and signals tile completion.

Parameters:
- DATA_WIDTH, 32, width of every weight/fmap word (FP32 bit pattern, passed through untouched).
- ROWS, 9, PE rows in the array.
- COLS, 8, PE columns in the array.
- MAC_LAT, 10, combined FPU_mul plus FPU_add_sub latency in cycles, used only for the drain count.

Ports:
- i_clk  in  1  clock.
- i_rest_n  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle start pulse; sampled only in IDLE.
- i_num_vec  in  16  number of fmap vectors in this tile; latched on accepted i_start.
- i_w_data  in  DATA_WIDTH  weight word; row-major, COLS words per row, ROWS rows.
- i_w_valid  in  1  weight word valid.
- o_w_ready  out  1  weight word accepted when i_w_valid and o_w_ready are both high.
- i_f_data  in  DATA_WIDTH  fmap word; ROWS words form one vector, word k goes to row k.
- i_f_valid  in  1  fmap word valid.
- o_f_ready  out  1  fmap handshake ready.
- o_weight_top  out  COLS*DATA_WIDTH  staged weight row, broadcast to the weight_f_top input of every PE in its column.
- o_weight_en  out  ROWS  one-hot row weight load enable.
- o_fmap_left  out  ROWS*DATA_WIDTH  per-row fmap into column 0.
- o_left_en  out  ROWS  per-row i_left_en.
- o_right_en  out  ROWS  per-row i_right_en; identical to o_left_en.
- o_busy  out  1  high in any state other than IDLE.
- o_done  out  1  one-cycle pulse at tile end.

Behaviour:
- Reset: all outputs 0, all counters 0, staging cleared, state IDLE. A reset asserted mid-operation aborts the tile immediately. No o_done is produced for the aborted tile.
- States: IDLE, LOAD_W, W_COMMIT, STREAM, F_LAUNCH, DRAIN, DONE.
- IDLE: on i_start, latch i_num_vec and go to LOAD_W. i_start in any other state is ignored.
- LOAD_W:
  - o_w_ready=1.
  - Each accepted word writes staging slot col_cnt, then col_cnt increments.
  - When slot COLS-1 is accepted, go to W_COMMIT.
- W_COMMIT (exactly 1 cycle):
  - o_w_ready=0.
  - o_weight_en[row_cnt]=1 and o_weight_top = staged row; no other weight_en bit is ever high.
  - row_cnt increments.
  - If row_cnt was ROWS-1: go to STREAM, or to DRAIN when the latched count is 0. Otherwise return to LOAD_W.
- o_weight_top holds its last value outside W_COMMIT.
- STREAM:
  - o_f_ready=1.
  - Accepted words fill fmap staging slot k.
  - When slot ROWS-1 is accepted, go to F_LAUNCH.
- F_LAUNCH (1 cycle):
  - o_f_ready=0.
  - The whole vector enters the skew lines: row r has data and enable delayed r cycles, so row 0 shows at cycle+1 and row 8 at cycle+9.
  - vec_cnt increments. Go to DRAIN if vec_cnt reaches the latched count, else go to STREAM.
- Sustained throughput is one vector per ROWS+1 cycles.
- o_left_en[r]=o_right_en[r]=1 for exactly the single cycle that o_fmap_left[r] carries a launched element; 0 otherwise. o_fmap_left[r] holds its value when not enabled.
- Skew lines keep shifting in DRAIN and DONE.
- DRAIN: counter loads (ROWS-1)+COLS+MAC_LAT on entry and decrements every cycle; go to DONE at 0.
- DONE: o_done=1 for one cycle, then IDLE.
- Input valid while the corresponding ready is low: the word is held off. Data is never dropped or duplicated.
- vec_cnt is 16 bits; i_num_vec=65535 completes without wrap.

Optional Feature:
- Macro PE_ARRAY_FEEDER_PERF_EN.
- Defined: adds output o_stall_cnt (32 bits, reset 0).
  - Cleared on accepted i_start.
  - Increments each STREAM cycle with o_f_ready=1 and i_f_valid=0.
  - Saturates at all-ones.
- Undefined: the port and the counter are absent; behaviour is otherwise identical.

Decomposition:
- Package pe_feed_pkg holds:
  - the state enum type;
  - localparams for counter widths ($clog2 of ROWS, COLS, and the drain maximum);
  - default DATA_WIDTH.
- Sub-module pe_skew_line: parameters DEPTH and DATA_WIDTH, a shift register of {en,data}; DEPTH=0 is a wire-through. Instantiated ROWS times via generate, with DEPTH=r.

Test Plan:
- Weight load, defaults:
  - Stimulus: start with num_vec=1; send 72 weight words 0x3F800000+i.
  - Required: o_weight_en walks 0x001..0x100 one-hot, once per row, each pulse one cycle. Row 2 commit shows o_weight_top word c = 0x3F800000+16+c.
  - Required: o_w_ready is low in each commit cycle.
- Skew:
  - Stimulus: one vector of words 0x40000000+k.
  - Required: o_left_en[k] pulses exactly k+1 cycles after F_LAUNCH with o_fmap_left[k]=0x40000000+k, and o_right_en equals o_left_en.
- Backpressure and completion:
  - Stimulus: i_f_valid toggled 1-0-1 every cycle over 3 vectors.
  - Required: all 27 words appear in order with none lost.
  - Required: o_done fires exactly 16+10 cycles after the last F_LAUNCH exit. With PE_ARRAY_FEEDER_PERF_EN, o_stall_cnt equals the count of valid-low ready-high STREAM cycles.
- Zero-vector tile:
  - Stimulus: num_vec=0.
  - Required: weights load, STREAM is skipped, and o_done follows the drain count with no left_en pulses.
- Reset mid-stream:
  - Stimulus: drop i_rest_n during vector 2.
  - Required: all outputs read 0 immediately, o_busy=0, no o_done.
  - Required: a following start runs a clean tile.
- Start ignored while busy:
  - Stimulus: i_start pulsed in STREAM with num_vec=5.
  - Required: the latched count is unchanged and the tile ends after the original count.
